alu_seq_core: RTL

- Clocked, width-parametrised successor to the combinational operator mux.
- Holds operand registers A and B.
- Accepts one command per handshake and produces a registered result Y with status flags.
- Adds a multi-cycle signed multiplier and a command/response handshake.
- Sits between the front-panel input/selector logic and the LED/result display path.

---
 rtl/alu_seq_pkg.sv | 49 ++++
 rtl/alu_seq_if.sv | 27 ++
 rtl/alu_mul_seq.sv | 77 +++++++
 rtl/alu_seq_core.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU core: opcodes, FSM state
// encoding, flag bit positions and a flag-packing helper.
package alu_seq_pkg;

   localparam int OP_W = 5;

   localparam logic [OP_W-1:0] OP_ADD  = 5'h00;
   localparam logic [OP_W-1:0] OP_SUB  = 5'h01;
   localparam logic [OP_W-1:0] OP_SHL  = 5'h02;
   localparam logic [OP_W-1:0] OP_SHR  = 5'h03;
   localparam logic [OP_W-1:0] OP_CMP  = 5'h04;
   localparam logic [OP_W-1:0] OP_AND  = 5'h05;
   localparam logic [OP_W-1:0] OP_OR   = 5'h06;
   localparam logic [OP_W-1:0] OP_XOR  = 5'h07;
   localparam logic [OP_W-1:0] OP_NAND = 5'h08;
   localparam logic [OP_W-1:0] OP_NOR  = 5'h09;
   localparam logic [OP_W-1:0] OP_XNOR = 5'h0A;
   localparam logic [OP_W-1:0] OP_NOT  = 5'h0B;
   localparam logic [OP_W-1:0] OP_NEG  = 5'h0C;
   localparam logic [OP_W-1:0] OP_STY  = 5'h0D;
   localparam logic [OP_W-1:0] OP_SWP  = 5'h0E;
   localparam logic [OP_W-1:0] OP_LDA  = 5'h0F;
   localparam logic [OP_W-1:0] OP_MUL  = 5'h10;
   localparam logic [OP_W-1:0] OP_LDB  = 5'h11;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam int FLAG_Z = 0;
   localparam int FLAG_N = 1;
   localparam int FLAG_C = 2;
   localparam int FLAG_V = 3;

   // Place individual status bits at their fixed positions in the flag word.
   function automatic logic [3:0] pack_flags(input logic v, input logic c,
                                             input logic n, input logic z);
      logic [3:0] f;
      f         = 4'b0000;
      f[FLAG_V] = v;
      f[FLAG_C] = c;
      f[FLAG_N] = n;
      f[FLAG_Z] = z;
      return f;
   endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Command/response bundle of the sequential ALU core. The master drives
// commands and observes results; the core is the slave.
interface alu_seq_if #(parameter int WIDTH = 8);
   import alu_seq_pkg::*;

   logic              cmd_valid;
   logic              cmd_ready;
   logic [OP_W-1:0]   opcode;
   logic [WIDTH-1:0]  data_in;
   logic              res_valid;
   logic [WIDTH-1:0]  Y;
   logic [3:0]        flags;
   logic              busy;
   logic [WIDTH-1:0]  ALed;
   logic [WIDTH-1:0]  BLed;

   modport master (
      output cmd_valid, opcode, data_in,
      input  cmd_ready, res_valid, Y, flags, busy, ALed, BLed
   );

   modport slave (
      input  cmd_valid, opcode, data_in,
      output cmd_ready, res_valid, Y, flags, busy, ALed, BLed
   );

endinterface

// File: rtl/alu_mul_seq.sv
// Iterative shift-add signed multiplier. Operands are latched on start,
// their magnitudes are multiplied over WIDTH cycles, and the sign is
// applied on the output. done pulses for one cycle when product is final
// and product holds until the next start.
module alu_mul_seq
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0]      CNT_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
   localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};

   logic [2*WIDTH-1:0] acc_r;
   logic [2*WIDTH-1:0] mcand_r;
   logic [WIDTH-1:0]   mplier_r;
   logic [CW-1:0]      cnt_r;
   logic               running_r;
   logic               done_r;
   logic               neg_r;

   // Two's-complement magnitude; the most-negative value maps to 2^(WIDTH-1).
   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
      return v[WIDTH-1] ? ((~v) + ONE_W) : v;
   endfunction

   // Operand capture on start, then one shift-add step per cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_r     <= '0;
         mcand_r   <= '0;
         mplier_r  <= '0;
         cnt_r     <= '0;
         running_r <= 1'b0;
         done_r    <= 1'b0;
         neg_r     <= 1'b0;
      end else if (start) begin
         acc_r     <= '0;
         mcand_r   <= {{WIDTH{1'b0}}, mag(a)};
         mplier_r  <= mag(b);
         cnt_r     <= '0;
         running_r <= 1'b1;
         done_r    <= 1'b0;
         neg_r     <= a[WIDTH-1] ^ b[WIDTH-1];
      end else if (running_r) begin
         if (mplier_r[0]) begin
            acc_r <= acc_r + mcand_r;
         end
         mcand_r  <= mcand_r << 1;
         mplier_r <= mplier_r >> 1;
         cnt_r    <= cnt_r + CNT_ONE;
         if (cnt_r == CNT_LAST) begin
            running_r <= 1'b0;
            done_r    <= 1'b1;
         end else begin
            done_r    <= 1'b0;
         end
      end else begin
         done_r <= 1'b0;
      end
   end

   assign done    = done_r;
   assign product = neg_r ? ((~acc_r) + ONE_2W) : acc_r;

endmodule

// File: rtl/alu_seq_core.sv
// Clocked ALU core with operand registers A/B, registered result Y and
// {V,C,N,Z} flags, driven through a valid/ready command handshake.
// Build option: define ALU_SEQ_MUL_EN to include the multi-cycle signed
// multiply on opcode 0x10; without it 0x10 is an illegal opcode.
module alu_seq_core
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic        clk,
   input  logic        reset,
   alu_seq_if.slave    bus
);

   localparam int                M       = WIDTH - 1;
   localparam logic [WIDTH-1:0]  ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0]  MIN_W   = {1'b1, {(WIDTH-1){1'b0}}};

   state_t             state_r, state_nxt;
   logic [WIDTH-1:0]   a_r, b_r, y_r;
   logic [3:0]         flags_r;
   logic               res_valid_r;

   logic [WIDTH-1:0]   a_nxt, b_nxt, y_nxt;
   logic [3:0]         flags_nxt;
   logic               res_valid_nxt;

   logic               accept_s;
   logic [WIDTH:0]     sum_s, diff_s;
   logic [WIDTH-1:0]   res_s;
   logic               v_s, c_s, wr_s, ill_s, op_is_mul_s;
   logic [WIDTH-1:0]   op_y_s, op_a_s, op_b_s;
   logic [3:0]         op_flags_s;

   logic               mul_start_s;
   logic               mul_done_s;
   logic [2*WIDTH-1:0] mul_product_s;
   logic [WIDTH:0]     mul_top_s;
   logic               mul_v_s;

   assign accept_s = bus.cmd_valid && (state_r == S_IDLE);
   assign sum_s    = {1'b0, a_r} + {1'b0, b_r};
   assign diff_s   = {1'b0, a_r} - {1'b0, b_r};

`ifdef ALU_SEQ_MUL_EN
   alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .reset   (reset),
      .start   (mul_start_s),
      .a       (a_r),
      .b       (b_r),
      .done    (mul_done_s),
      .product (mul_product_s)
   );
   assign bus.busy = (state_r != S_IDLE);
`else
   assign mul_done_s    = 1'b0;
   assign mul_product_s = '0;
   assign bus.busy      = 1'b0;
`endif

   // Product overflows WIDTH when its upper bits are not a pure sign extension.
   assign mul_top_s = mul_product_s[2*WIDTH-1:WIDTH-1];
   assign mul_v_s   = !((&mul_top_s) || !(|mul_top_s));

   // Decode the presented opcode into next Y/flags/A/B values.
   always_comb begin
      res_s       = '0;
      v_s         = 1'b0;
      c_s         = 1'b0;
      wr_s        = 1'b0;
      ill_s       = 1'b0;
      op_is_mul_s = 1'b0;
      op_y_s      = y_r;
      op_flags_s  = flags_r;
      op_a_s      = a_r;
      op_b_s      = b_r;
      case (bus.opcode)
         OP_ADD:  begin res_s = sum_s[M:0];  c_s = sum_s[WIDTH];  wr_s = 1'b1;
                        v_s = (a_r[M] == b_r[M]) && (res_s[M] != a_r[M]); end
         OP_SUB:  begin res_s = diff_s[M:0]; c_s = diff_s[WIDTH]; wr_s = 1'b1;
                        v_s = (a_r[M] != b_r[M]) && (res_s[M] != a_r[M]); end
         OP_SHL:  begin res_s = a_r << 1; c_s = a_r[M]; v_s = a_r[M] ^ a_r[M-1]; wr_s = 1'b1; end
         OP_SHR:  begin res_s = {a_r[M], a_r[M:1]}; c_s = a_r[0]; wr_s = 1'b1; end
         OP_CMP:  begin
                     wr_s = 1'b1;
                     if ($signed(a_r) > $signed(b_r)) begin
                        res_s = ONE_W;
                     end else if ($signed(a_r) < $signed(b_r)) begin
                        res_s = {WIDTH{1'b1}};
                     end else begin
                        res_s = '0;
                     end
                  end
         OP_AND:  begin res_s = a_r & b_r;    wr_s = 1'b1; end
         OP_OR:   begin res_s = a_r | b_r;    wr_s = 1'b1; end
         OP_XOR:  begin res_s = a_r ^ b_r;    wr_s = 1'b1; end
         OP_NAND: begin res_s = ~(a_r & b_r); wr_s = 1'b1; end
         OP_NOR:  begin res_s = ~(a_r | b_r); wr_s = 1'b1; end
         OP_XNOR: begin res_s = ~(a_r ^ b_r); wr_s = 1'b1; end
         OP_NOT:  begin res_s = ~a_r;         wr_s = 1'b1; end
         OP_NEG:  begin res_s = -a_r; v_s = (a_r == MIN_W); wr_s = 1'b1; end
         OP_STY:  op_a_s = y_r;
         OP_SWP:  begin op_a_s = b_r; op_b_s = a_r; end
         OP_LDA:  op_a_s = bus.data_in;
`ifdef ALU_SEQ_MUL_EN
         OP_MUL:  op_is_mul_s = 1'b1;
`endif
         OP_LDB:  op_b_s = bus.data_in;
         default: ill_s = 1'b1;
      endcase
      if (wr_s) begin
         op_y_s     = res_s;
         op_flags_s = pack_flags(v_s, c_s, res_s[M], (res_s == '0));
      end else if (ill_s) begin
         op_y_s     = '0;
         op_flags_s = 4'b0000;
      end else begin
         op_y_s     = y_r;
         op_flags_s = flags_r;
      end
   end

   // Next-state and register-update selection for IDLE/MUL/DONE.
   always_comb begin
      state_nxt     = state_r;
      a_nxt         = a_r;
      b_nxt         = b_r;
      y_nxt         = y_r;
      flags_nxt     = flags_r;
      res_valid_nxt = 1'b0;
      mul_start_s   = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (accept_s && op_is_mul_s) begin
               mul_start_s = 1'b1;
               state_nxt   = S_MUL;
            end else if (accept_s) begin
               a_nxt         = op_a_s;
               b_nxt         = op_b_s;
               y_nxt         = op_y_s;
               flags_nxt     = op_flags_s;
               res_valid_nxt = 1'b1;
            end else begin
               state_nxt = S_IDLE;
            end
         end
         S_MUL: begin
            if (mul_done_s) begin
               state_nxt = S_DONE;
            end else begin
               state_nxt = S_MUL;
            end
         end
         S_DONE: begin
            y_nxt         = mul_product_s[M:0];
            flags_nxt     = pack_flags(mul_v_s, 1'b0, mul_product_s[M],
                                       (mul_product_s[M:0] == '0));
            res_valid_nxt = 1'b1;
            state_nxt     = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any multiply in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r     <= S_IDLE;
         a_r         <= '0;
         b_r         <= '0;
         y_r         <= '0;
         flags_r     <= 4'b0000;
         res_valid_r <= 1'b0;
      end else begin
         state_r     <= state_nxt;
         a_r         <= a_nxt;
         b_r         <= b_nxt;
         y_r         <= y_nxt;
         flags_r     <= flags_nxt;
         res_valid_r <= res_valid_nxt;
      end
   end

   assign bus.cmd_ready = (state_r == S_IDLE);
   assign bus.res_valid = res_valid_r;
   assign bus.Y         = y_r;
   assign bus.flags     = flags_r;
   assign bus.ALed      = a_r;
   assign bus.BLed      = b_r;

endmodule
